// File: rtl/alu_pkg.sv
// Shared opcode, state and flag definitions for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_MUL = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_NOT = 4;
  localparam int unsigned OP_SUB = 5;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/seq_multer.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module seq_multer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_step;

  // done_o flags the final step; product_o already includes that step's partial product.
  always_comb begin
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    done_o    = busy_q && (cnt_q == CntW'(WIDTH - 1));
    product_o = acc_step;

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with registered result and flags; MUL runs on seq_multer.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] alu_component_select,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_1,
  output logic [WIDTH-1:0] output_hi,
  output logic [3:0]       flags
);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [3:0]         flags_q, flags_d;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flags;
  logic [3:0]         mul_flags;

  seq_multer #(
    .WIDTH(WIDTH)
  ) u_multer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (input_1),
    .b_i      (input_2),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // Single-cycle ops evaluated straight from the inputs, registered on accept.
  always_comb begin
    sum       = {1'b0, input_1} + {1'b0, input_2};
    diff      = {1'b0, input_1} - {1'b0, input_2};
    alu_res   = input_1;
    alu_flags = '0;
    case (alu_component_select)
      SEL_W'(OP_ADD): begin
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_V] = (input_1[WIDTH-1] == input_2[WIDTH-1]) &&
                            (sum[WIDTH-1] != input_1[WIDTH-1]);
      end
      SEL_W'(OP_SUB): begin
        alu_res           = diff[WIDTH-1:0];
        alu_flags[FLAG_C] = diff[WIDTH];
        alu_flags[FLAG_V] = (input_1[WIDTH-1] != input_2[WIDTH-1]) &&
                            (diff[WIDTH-1] != input_1[WIDTH-1]);
      end
      SEL_W'(OP_AND): alu_res = input_1 & input_2;
      SEL_W'(OP_OR):  alu_res = input_1 | input_2;
      SEL_W'(OP_NOT): alu_res = ~input_1;
      default:        alu_res = input_1;
    endcase
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[WIDTH-1];

    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product == '0);
    mul_flags[FLAG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
    mul_flags[FLAG_N] = mul_product[2*WIDTH-1];
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    hi_d      = hi_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (alu_component_select == SEL_W'(OP_MUL)) begin
            mul_start = 1'b1;
            state_d   = BUSY;
          end else begin
            res_d   = alu_res;
            hi_d    = '0;
            flags_d = alu_flags;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          res_d   = mul_product[WIDTH-1:0];
          hi_d    = mul_product[2*WIDTH-1:WIDTH];
          flags_d = mul_flags;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign output_1  = res_q;
  assign output_hi = hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vectors, randomized ops vs. arithmetic model,
// backpressure, and reset abort of a multiply.
module tb_seq_alu;

  localparam int unsigned W = 8;
  localparam longint MAXS = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINS = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   sel = '0;
  logic [W-1:0] input_1 = '0;
  logic [W-1:0] input_2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] output_1;
  logic [W-1:0] output_hi;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] r_res, r_hi;
  logic [3:0]   r_fl;
  int           r_lat;
  bit           r_rdy, r_busy_rdy;

  seq_alu #(
    .WIDTH(W),
    .SEL_W(4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .alu_component_select(sel),
    .input_1             (input_1),
    .input_2             (input_2),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .output_1            (output_1),
    .output_hi           (output_hi),
    .flags               (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // Reference: plain integer arithmetic; flags returned as {n, v, c, z}.
  task automatic model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] h, output logic [3:0] f);
    longint ua, ub, u, sa, sb, s;
    bit c, v, z, n;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 0; v = 0; h = '0; u = 0;
    case (op)
      0: begin
        u = ua + ub; s = sa + sb; r = W'(u);
        c = (u >= (64'sd1 <<< W)); v = (s > MAXS) || (s < MINS);
      end
      1: begin
        u = ua * ub; r = W'(u); h = W'(u >>> W); c = (h != 0);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = ~a;
      5: begin
        u = ua - ub; s = sa - sb; r = W'(u);
        c = (ua < ub); v = (s > MAXS) || (s < MINS);
      end
      default: r = a;
    endcase
    z = (op == 1) ? (u == 0) : (r == 0);
    n = (op == 1) ? h[W-1] : r[W-1];
    f = {n, v, c, z};
  endtask

  // Starts at a negedge; issues one op, waits for out_valid, optionally consumes it.
  task automatic do_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit consume);
    r_rdy = in_ready;
    in_valid = 1'b1;
    sel = 4'(op);
    input_1 = a;
    input_2 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sel = 4'($urandom);
    input_1 = W'($urandom);
    input_2 = W'($urandom);
    r_lat = 1;
    r_busy_rdy = 0;
    while (!out_valid && r_lat < 64) begin
      if (in_ready) r_busy_rdy = 1;
      @(negedge clk);
      r_lat++;
    end
    r_res = output_1;
    r_hi = output_hi;
    r_fl = flags;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got vld=%b rdy=%b want 0 0", out_valid, in_ready);
    end
    checks++;
    if (output_1 !== '0 || output_hi !== '0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %h want 0 0 0", output_1, output_hi, flags);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  typedef struct {
    int op; logic [W-1:0] a, b, res, hi; logic [3:0] fl; int lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[13] = '{
      '{0, 8'd200, 8'd100, 8'd44,  8'h00, 4'b0010, 1},
      '{0, 8'd100, 8'd100, 8'd200, 8'h00, 4'b1100, 1},
      '{5, 8'd5,   8'd7,   8'd254, 8'h00, 4'b1010, 1},
      '{1, 8'd255, 8'd255, 8'h01,  8'hFE, 4'b1010, 9},
      '{1, 8'd15,  8'd17,  8'd255, 8'h00, 4'b0000, 9},
      '{1, 8'd0,   8'd123, 8'd0,   8'h00, 4'b0001, 9},
      '{2, 8'hF0,  8'h3C,  8'h30,  8'h00, 4'b0000, 1},
      '{3, 8'hF0,  8'h0F,  8'hFF,  8'h00, 4'b1000, 1},
      '{4, 8'h0F,  8'h55,  8'hF0,  8'h00, 4'b1000, 1},
      '{4, 8'hFF,  8'h00,  8'h00,  8'h00, 4'b0001, 1},
      '{9, 8'h80,  8'h12,  8'h80,  8'h00, 4'b1000, 1},
      '{5, 8'h80,  8'h01,  8'h7F,  8'h00, 4'b0100, 1},
      '{0, 8'd0,   8'd0,   8'd0,   8'h00, 4'b0001, 1}
    };
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      checks++;
      if (r_res !== vecs[i].res || r_hi !== vecs[i].hi || r_fl !== vecs[i].fl) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d got res=%h hi=%h fl=%b want %h %h %b", i,
                 vecs[i].op, r_res, r_hi, r_fl, vecs[i].res, vecs[i].hi, vecs[i].fl);
      end
      checks++;
      if (r_lat !== vecs[i].lat || r_rdy !== 1'b1 || r_busy_rdy !== 1'b0) begin
        errors++;
        $display("FAIL directed_timing[%0d] got lat=%0d rdy=%b busy_rdy=%b want %0d 1 0", i,
                 r_lat, r_rdy, r_busy_rdy, vecs[i].lat);
      end
    end
  endtask

  task automatic test_random_back_to_back();
    int op;
    logic [W-1:0] a, b, er, eh;
    logic [3:0] ef;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      model(op, a, b, er, eh, ef);
      do_op(op, a, b, 1'b1);
      checks++;
      if (r_res !== er || r_hi !== eh || r_fl !== ef) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got %h %h %b want %h %h %b", i, op, a, b,
                 r_res, r_hi, r_fl, er, eh, ef);
      end
      checks++;
      if (r_lat !== ((op == 1) ? int'(W) + 1 : 1) || r_rdy !== 1'b1) begin
        errors++;
        $display("FAIL random_timing[%0d] op=%0d got lat=%0d rdy=%b", i, op, r_lat, r_rdy);
      end
    end
  endtask

  task automatic test_backpressure();
    bit bad_hold = 0;
    do_op(0, 8'd1, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      sel = 4'($urandom_range(0, 5));
      input_1 = W'($urandom);
      input_2 = W'($urandom);
      #1;
      if (out_valid !== 1'b1 || output_1 !== 8'd2 || output_hi !== '0 || flags !== 4'b0000 ||
          in_ready !== 1'b0) bad_hold = 1;
      @(negedge clk);
    end
    checks++;
    if (bad_hold) begin
      errors++;
      $display("FAIL backpressure_hold got vld=%b res=%h fl=%b want 1 02 0000",
               out_valid, output_1, flags);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    do_op(3, 8'h0C, 8'h03, 1'b1);
    checks++;
    if (r_res !== 8'h0F || r_rdy !== 1'b1 || r_lat !== 1) begin
      errors++;
      $display("FAIL backpressure_next got res=%h rdy=%b lat=%0d want 0f 1 1", r_res, r_rdy,
               r_lat);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit saw_valid = 0;
    in_valid = 1'b1;
    sel = 4'd1;
    input_1 = 8'd255;
    input_2 = 8'd255;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || output_1 !== '0 || output_hi !== '0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_mul got vld=%b %h %h %b want 0 00 00 0000", out_valid,
               output_1, output_hi, flags);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mul_ready got %b want 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL reset_mid_mul_abort got out_valid=1 want 0");
    end
    do_op(2, 8'hF0, 8'h3C, 1'b1);
    checks++;
    if (r_res !== 8'h30 || r_hi !== '0 || r_fl !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_mul_fresh got %h %h %b want 30 00 0000", r_res, r_hi, r_fl);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the 8-bit combinational ALU. It is a WIDTH-bit ALU with valid/ready input and output channels, registered results, and a status-flag output. It adds SUB, AND, OR and NOT. Multiply is iterative shift-add (WIDTH cycles) and returns the full 2*WIDTH product. It sits between the CPU decode/register-read stage and writeback; one operation is in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SEL_W, 4, width of alu_component_select

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and select are valid
in_ready  output  1  block can accept an operation
alu_component_select  input  SEL_W  opcode, sampled on accept
input_1  input  WIDTH  operand A, sampled on accept
input_2  input  WIDTH  operand B, sampled on accept
out_valid  output  1  result registers hold a completed result
out_ready  input  1  consumer takes the result
output_1  output  WIDTH  result, low half for MUL
output_hi  output  WIDTH  MUL high half, 0 for all other ops
flags  output  4  {negative, overflow, carry, zero}

Behaviour:
- Opcodes: 0 ADD, 1 MUL, 2 AND, 3 OR, 4 NOT (~input_1), 5 SUB (input_1-input_2). Any other code is PASS (output_1=input_1).
- Accept: in_valid & in_ready on a rising edge. Operands and opcode are captured in internal registers; input changes after accept have no effect.
- in_ready = (state==IDLE) & ~rst. There is no accept while BUSY or DONE.
- FSM states:
  - IDLE: on accept of a non-MUL op, compute and go to DONE. On accept of MUL, go to BUSY with count=0.
  - BUSY: one shift-add step per cycle. After WIDTH steps, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency (accept edge N): non-MUL out_valid high from cycle N+1; MUL out_valid high from cycle N+1+WIDTH.
- Backpressure: in DONE with out_ready=0, output_1, output_hi, flags and out_valid hold stable indefinitely.
- Throughput: the earliest new accept is the cycle after the out_valid&out_ready edge (state back in IDLE).
- Arithmetic: all ops unsigned modulo 2^WIDTH, except overflow, which uses the two's-complement interpretation.
- Flags, all computed on result registration:
  - zero: output_1==0. For MUL, zero requires the full product ==0.
  - carry: ADD carry-out; SUB borrow (A<B unsigned); MUL output_hi!=0; logic ops 0.
  - overflow: signed overflow for ADD/SUB; 0 otherwise.
  - negative: output_1[WIDTH-1] (output_hi[WIDTH-1] for MUL).
- Reset: output_1, output_hi, flags = 0; out_valid=0; state IDLE; count=0. Reset mid-BUSY or mid-DONE aborts the op, and the result is never presented.
- in_valid held while in BUSY/DONE is ignored. No operation is queued.

Decomposition:
- alu_pkg holds:
  - opcode localparams OP_ADD..OP_SUB
  - state encoding IDLE/BUSY/DONE
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3
- One sub-module, seq_multer: WIDTH-parameterised shift-add core.
  - Inputs: start, a, b. Outputs: done, product[2*WIDTH-1:0].
  - Shares clk/rst with seq_alu.
  - seq_alu's FSM sequences it.

Test Plan:
- ADD 200+100 (WIDTH=8) -> output_1=44, carry=1, overflow=0, zero=0; out_valid 1 cycle after accept.
- ADD 100+100 -> output_1=200, overflow=1, negative=1, carry=0. SUB 5-7 -> output_1=254, carry(borrow)=1, negative=1.
- MUL 255*255 -> output_1=0x01, output_hi=0xFE, carry=1; out_valid exactly 9 cycles after accept; in_ready=0 throughout.
- MUL 15*17 -> output_1=255, output_hi=0, carry=0. MUL 0*123 -> zero=1, product 0.
- Backpressure: ADD 1+1, hold out_ready=0 for 5 cycles -> output_1=2 stable and out_valid=1 throughout. Toggling in_valid/inputs in that window is not accepted. out_ready=1 -> IDLE, next op accepted the following cycle.
- Reset mid-MUL (rst at BUSY step 3) -> next cycle out_valid=0, outputs/flags 0, in_ready=1 after rst drops. A fresh AND 0xF0&0x3C returns 0x30.
